// File: rtl/asu_pkg.sv
// Shared definitions for the ASU arbiter: default operand width, FSM state
// encoding and the ASU mode constants understood by the external ASU.
package asu_pkg;

  localparam int ASU_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } asu_state_t;

  localparam logic ASU_MODE_ADD = 1'b0;
  localparam logic ASU_MODE_SUB = 1'b1;

endpackage

// File: rtl/asu_arb_rr_arb2.sv
// Two-way round-robin grant. ready[i] depends only on the other requester's
// valid and the pointer; grant = ready & valid is therefore one-hot.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] ready,
  output logic [1:0] grant
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign ready[gi] = en & (~valid[1-gi] | (ptr == 1'(gi)));
      assign grant[gi] = ready[gi] & valid[gi];
    end
  endgenerate

endmodule

// File: rtl/asu_arb.sv
// Arbiter sharing one external combinational ASU between two requesters.
// Optional per-requester grant counters are enabled by defining ASU_ARB_STATS_EN.
module asu_arb
  import asu_pkg::*;
#(
  parameter int DATA_W = ASU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_mode,
  input  logic [DATA_W-1:0] req_x0,
  input  logic [DATA_W-1:0] req_y0,
  input  logic [DATA_W-1:0] req_x1,
  input  logic [DATA_W-1:0] req_y1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W:0]   rsp_data,
  output logic [DATA_W-1:0] asu_x,
  output logic [DATA_W-1:0] asu_y,
  output logic              asu_mode,
  input  logic              asu_carry,
  input  logic [DATA_W-1:0] asu_out
`ifdef ASU_ARB_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  asu_state_t        state_reg;
  asu_state_t        state_next;
  logic              ptr_reg;
  logic              owner_reg;
  logic [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] y_reg;
  logic              mode_reg;
  logic [DATA_W:0]   result_reg;

  logic              arb_en;
  logic [1:0]        arb_ready;
  logic [1:0]        arb_grant;
  logic              accept;
  logic              accept_id;

  // Gating with rst_n keeps both handshakes quiet while reset is held.
  assign arb_en    = rst_n && (state_reg == ST_IDLE);
  assign accept    = |arb_grant;
  assign accept_id = arb_grant[1];

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (ptr_reg),
    .en    (arb_en),
    .ready (arb_ready),
    .grant (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready[owner_reg]) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = arb_ready;
    rsp_valid = 2'b00;
    if (rst_n && (state_reg == ST_RESP)) begin
      rsp_valid[owner_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg    <= 1'b0;
      owner_reg  <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      mode_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        owner_reg <= accept_id;
        ptr_reg   <= ~accept_id;
        x_reg     <= accept_id ? req_x1 : req_x0;
        y_reg     <= accept_id ? req_y1 : req_y0;
        mode_reg  <= req_mode[accept_id];
      end
      if (state_reg == ST_EXEC) begin
        result_reg <= {asu_carry, asu_out};
      end
    end
  end

  // Operand registers drive the ASU permanently, so its inputs stay put when idle.
  assign asu_x    = x_reg;
  assign asu_y    = y_reg;
  assign asu_mode = mode_reg;
  assign rsp_data = result_reg;

`ifdef ASU_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [7:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= 8'h00;
        end else if (arb_grant[gi] && (cnt_reg != 8'hFF)) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule
